// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: synchronises rx_in, qualifies the start bit and times
// each bit from a programmable clocks-per-bit value, majority-voting three mid-bit samples.
module uart_rx_ctrl #(
  parameter int CPB_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_en,
  input  logic [CPB_W-1:0] clks_per_bit,
  input  logic             par_en,
  input  logic             par_typ,
  input  logic             rx_in,
  output logic             busy,
  output logic             bit_strobe,
  output logic [3:0]       bit_idx,
  output logic             bit_val,
  output logic             frame_done,
  output logic [7:0]       rx_data,
  output logic             par_error,
  output logic             stop_error,
  output logic             false_start
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [CPB_W-1:0] CPB_MIN = CPB_W'(4);

  state_t           state;
  logic             sync1;
  logic             rx_s;
  logic             rx_p;
  logic [CPB_W-1:0] cpb;
  logic [CPB_W-1:0] cnt;
  logic [CPB_W-1:0] cnt_next;
  logic [CPB_W-1:0] half;
  logic             cfg_par_en;
  logic             cfg_par_typ;
  logic [2:0]       n;
  logic [7:0]       shreg;
  logic             s_lo;
  logic             s_mid;
  logic             perr;
  logic             fall;
  logic             vote;
  logic             at_vote;
  logic             cnt_last;

  assign fall     = rx_p & ~rx_s;
  assign half     = cpb >> 1;
  assign at_vote  = (cnt == half + CPB_W'(1));
  assign cnt_last = (cnt == cpb - CPB_W'(1));
  assign cnt_next = cnt_last ? '0 : cnt + CPB_W'(1);
  // Third sample is taken live from rx_s so the vote lands in the same cycle.
  assign vote     = (s_lo & s_mid) | (s_lo & rx_s) | (s_mid & rx_s);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
      rx_p  <= 1'b1;
    end else begin
      sync1 <= rx_in;
      rx_s  <= sync1;
      rx_p  <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_lo  <= 1'b0;
      s_mid <= 1'b0;
    end else begin
      if (cnt == half - CPB_W'(1)) s_lo <= rx_s;
      if (cnt == half) s_mid <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      cpb         <= '0;
      cfg_par_en  <= 1'b0;
      cfg_par_typ <= 1'b0;
      n           <= '0;
      shreg       <= '0;
      perr        <= 1'b0;
      busy        <= 1'b0;
      bit_strobe  <= 1'b0;
      bit_idx     <= '0;
      bit_val     <= 1'b0;
      frame_done  <= 1'b0;
      rx_data     <= '0;
      par_error   <= 1'b0;
      stop_error  <= 1'b0;
      false_start <= 1'b0;
    end else begin
      bit_strobe  <= 1'b0;
      frame_done  <= 1'b0;
      false_start <= 1'b0;
      if (!rx_en) begin
        state <= IDLE;
        busy  <= 1'b0;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            cnt <= '0;
            if (fall) begin
              state       <= START;
              busy        <= 1'b1;
              cpb         <= (clks_per_bit < CPB_MIN) ? CPB_MIN : clks_per_bit;
              cfg_par_en  <= par_en;
              cfg_par_typ <= par_typ;
            end
          end
          START: begin
            cnt <= cnt_next;
            if (at_vote && vote) begin
              false_start <= 1'b1;
              state       <= IDLE;
              busy        <= 1'b0;
            end else if (cnt_last) begin
              state <= DATA;
              n     <= '0;
            end
          end
          DATA: begin
            cnt <= cnt_next;
            if (at_vote) begin
              bit_strobe <= 1'b1;
              bit_idx    <= {1'b0, n};
              bit_val    <= vote;
              shreg[n]   <= vote;
            end
            if (cnt_last) begin
              if (n == 3'd7) state <= cfg_par_en ? PARITY : STOP;
              else n <= n + 3'd1;
            end
          end
          PARITY: begin
            cnt <= cnt_next;
            if (at_vote) begin
              bit_strobe <= 1'b1;
              bit_idx    <= 4'd8;
              bit_val    <= vote;
              perr       <= ^shreg ^ vote ^ cfg_par_typ;
            end
            if (cnt_last) state <= STOP;
          end
          STOP: begin
            cnt <= cnt_next;
            // The frame completes at the stop-bit vote so back-to-back frames can start early.
            if (at_vote) begin
              bit_strobe <= 1'b1;
              bit_idx    <= 4'd9;
              bit_val    <= vote;
              frame_done <= 1'b1;
              rx_data    <= shreg;
              stop_error <= ~vote;
              par_error  <= cfg_par_en & perr;
              state      <= IDLE;
              busy       <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: frames are described at bit level, expected
// strobes and frame results are queued, and a monitor pops them as the DUT reports.
module tb_uart_rx_ctrl;

  localparam int CPB_W = 12;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             rx_en = 1'b0;
  logic [CPB_W-1:0] clks_per_bit = CPB_W'(16);
  logic             par_en = 1'b0;
  logic             par_typ = 1'b0;
  logic             rx_in = 1'b1;
  logic             busy;
  logic             bit_strobe;
  logic [3:0]       bit_idx;
  logic             bit_val;
  logic             frame_done;
  logic [7:0]       rx_data;
  logic             par_error;
  logic             stop_error;
  logic             false_start;

  uart_rx_ctrl #(.CPB_W(CPB_W)) dut (
    .clk(clk), .rst(rst), .rx_en(rx_en), .clks_per_bit(clks_per_bit),
    .par_en(par_en), .par_typ(par_typ), .rx_in(rx_in), .busy(busy),
    .bit_strobe(bit_strobe), .bit_idx(bit_idx), .bit_val(bit_val),
    .frame_done(frame_done), .rx_data(rx_data), .par_error(par_error),
    .stop_error(stop_error), .false_start(false_start)
  );

  always #5 clk = ~clk;

  int         compared = 0;
  int         mismatched = 0;
  int         cyc = 0;
  int         last_strobe_cyc = 0;
  int         cur_cpb = 16;
  int         exp_idx[$];
  bit         exp_val[$];
  logic [7:0] exp_data[$];
  bit         exp_perr[$];
  bit         exp_serr[$];
  bit         exp_fs[$];
  logic [7:0] model_rx_data = 8'h00;
  bit         model_perr = 1'b0;
  bit         model_serr = 1'b0;

  task automatic checkOutput(input string name, input int actual, input int required);
    compared++;
    if (actual != required) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, required %0d (cycle %0d)", name, actual, required, cyc);
    end
  endtask

  task automatic checkHeld();
    checkOutput("held_rx_data", rx_data, model_rx_data);
    checkOutput("held_par_error", par_error, model_perr);
    checkOutput("held_stop_error", stop_error, model_serr);
  endtask

  task automatic driveBit(input logic v, input int cycles);
    rx_in = v;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((exp_idx.size() + exp_data.size() + exp_fs.size()) != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_within_budget", int'(n < 400), 1);
    exp_idx.delete(); exp_val.delete(); exp_data.delete();
    exp_perr.delete(); exp_serr.delete(); exp_fs.delete();
  endtask

  // Reference model: a frame is a list of bits; the receiver must report each one
  // in order, then the assembled byte with its parity and framing verdicts.
  task automatic applyStimulus(input int cfg, input bit pe, input bit pt, input logic [7:0] data,
                               input bit pbit, input bit stop_bit, input int gap);
    int eff = (cfg < 4) ? 4 : cfg;
    int ones;
    bit perr;
    clks_per_bit = CPB_W'(cfg);
    par_en = pe;
    par_typ = pt;
    cur_cpb = eff;
    for (int i = 0; i < 8; i++) begin
      exp_idx.push_back(i);
      exp_val.push_back(data[i]);
    end
    if (pe) begin
      exp_idx.push_back(8);
      exp_val.push_back(pbit);
    end
    exp_idx.push_back(9);
    exp_val.push_back(stop_bit);
    ones = $countones(data) + (pe ? int'(pbit) : 0);
    perr = pe ? ((ones % 2) != int'(pt)) : 1'b0;
    exp_data.push_back(data);
    exp_perr.push_back(perr);
    exp_serr.push_back(!stop_bit);
    model_rx_data = data;
    model_perr = perr;
    model_serr = !stop_bit;
    driveBit(1'b0, eff);
    for (int i = 0; i < 8; i++) driveBit(data[i], eff);
    if (pe) driveBit(pbit, eff);
    driveBit(stop_bit, eff);
    driveBit(1'b1, gap);
    waitDrain();
    checkHeld();
  endtask

  // Sends start plus data bits 0..3, then cuts the frame early in data bit 4.
  task automatic abortFrame(input bit use_reset, input int cfg, input logic [7:0] data);
    int eff = (cfg < 4) ? 4 : cfg;
    int half = eff / 2;
    clks_per_bit = CPB_W'(cfg);
    par_en = 1'b0;
    cur_cpb = eff;
    for (int i = 0; i < 4; i++) begin
      exp_idx.push_back(i);
      exp_val.push_back(data[i]);
    end
    driveBit(1'b0, eff);
    for (int i = 0; i < 4; i++) driveBit(data[i], eff);
    driveBit(data[4], half + 2);
    if (use_reset) begin
      rst = 1'b0;
      #1;
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_bit_strobe", bit_strobe, 0);
      checkOutput("rst_bit_idx", bit_idx, 0);
      checkOutput("rst_bit_val", bit_val, 0);
      checkOutput("rst_frame_done", frame_done, 0);
      checkOutput("rst_rx_data", rx_data, 0);
      checkOutput("rst_par_error", par_error, 0);
      checkOutput("rst_stop_error", stop_error, 0);
      checkOutput("rst_false_start", false_start, 0);
      checkOutput("rst_strobes_seen", exp_idx.size(), 0);
      exp_idx.delete();
      exp_val.delete();
      model_rx_data = 8'h00;
      model_perr = 1'b0;
      model_serr = 1'b0;
      rx_in = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
    end else begin
      rx_en = 1'b0;
      rx_in = 1'b1;
      @(negedge clk);
      checkOutput("abort_busy", busy, 0);
      repeat (5) @(negedge clk);
      rx_en = 1'b1;
      @(negedge clk);
      waitDrain();
      checkHeld();
    end
  endtask

  task automatic monitorLoop();
    int e_idx;
    bit e_val;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        if (bit_strobe) begin
          checkOutput("strobe_expected", int'(exp_idx.size() > 0), 1);
          if (exp_idx.size() > 0) begin
            e_idx = exp_idx.pop_front();
            e_val = exp_val.pop_front();
            checkOutput("bit_idx", bit_idx, e_idx);
            checkOutput("bit_val", bit_val, e_val);
            if (e_idx != 0) checkOutput("strobe_spacing", cyc - last_strobe_cyc, cur_cpb);
          end
          last_strobe_cyc = cyc;
        end
        if (frame_done) begin
          checkOutput("frame_expected", int'(exp_data.size() > 0), 1);
          if (exp_data.size() > 0) begin
            checkOutput("rx_data", rx_data, exp_data.pop_front());
            checkOutput("par_error", par_error, exp_perr.pop_front());
            checkOutput("stop_error", stop_error, exp_serr.pop_front());
          end
          checkOutput("busy_at_done", busy, 0);
        end
        if (false_start) begin
          checkOutput("false_start_expected", int'(exp_fs.size() > 0), 1);
          if (exp_fs.size() > 0) void'(exp_fs.pop_front());
          checkOutput("busy_at_false_start", busy, 0);
          checkOutput("strobe_with_false_start", bit_strobe, 0);
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cfg;
    bit pe;
    bit pt;
    bit pb;
    bit sb;
    int gap;
    logic [7:0] d;

    fork
      monitorLoop();
    join_none

    repeat (3) @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_bit_strobe", bit_strobe, 0);
    checkOutput("reset_bit_idx", bit_idx, 0);
    checkOutput("reset_bit_val", bit_val, 0);
    checkOutput("reset_frame_done", frame_done, 0);
    checkOutput("reset_rx_data", rx_data, 0);
    checkOutput("reset_par_error", par_error, 0);
    checkOutput("reset_stop_error", stop_error, 0);
    checkOutput("reset_false_start", false_start, 0);
    rst = 1'b1;
    rx_en = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] basic frame 0xA5, no parity");
    applyStimulus(16, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 3);

    $display("[TB] parity frames");
    applyStimulus(8, 1'b1, 1'b0, 8'h03, 1'b0, 1'b1, 2);
    applyStimulus(8, 1'b1, 1'b0, 8'h03, 1'b1, 1'b1, 2);
    applyStimulus(8, 1'b1, 1'b1, 8'h03, 1'b1, 1'b1, 2);

    $display("[TB] false start");
    clks_per_bit = CPB_W'(16);
    cur_cpb = 16;
    exp_fs.push_back(1'b1);
    driveBit(1'b0, 3);
    driveBit(1'b1, 30);
    waitDrain();
    checkOutput("false_start_busy", busy, 0);
    checkHeld();

    $display("[TB] stop error then recovery");
    applyStimulus(16, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 2);
    applyStimulus(16, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 2);

    $display("[TB] receiver disabled mid-frame");
    abortFrame(1'b0, 16, 8'h96);
    applyStimulus(16, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 2);

    $display("[TB] clks_per_bit below minimum");
    applyStimulus(2, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 0);

    $display("[TB] random frames");
    for (int k = 0; k < 12; k++) begin
      cfg = $urandom_range(2, 24);
      pe  = 1'($urandom_range(0, 1));
      pt  = 1'($urandom_range(0, 1));
      pb  = 1'($urandom_range(0, 1));
      sb  = ($urandom_range(0, 3) != 0);
      d   = 8'($urandom);
      gap = sb ? $urandom_range(0, 4) : $urandom_range(1, 4);
      applyStimulus(cfg, pe, pt, d, pb, sb, gap);
    end

    $display("[TB] reset mid-frame");
    abortFrame(1'b1, 6, 8'h5C);
    applyStimulus(10, 1'b1, 1'b1, 8'h7E, 1'b1, 1'b1, 2);

    repeat (20) @(negedge clk);
    checkOutput("leftover_strobes", exp_idx.size(), 0);
    checkOutput("leftover_frames", exp_data.size(), 0);
    checkOutput("final_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side sequencer for the UART. It synchronises the serial line, detects and qualifies the start bit, and times each bit period from a programmable clocks-per-bit value. It majority-votes three mid-bit samples per bit, issues per-bit sample strobes, and checks parity and stop bits. It sits between the rx pin and the byte consumer, replacing the external start/step sequencing the deserializer needs.

Parameters:
CPB_W, 12, width of clks_per_bit.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous active-low reset.
rx_en  in  1  receiver enable; low forces IDLE.
clks_per_bit  in  CPB_W  clock cycles per bit; values <4 treated as 4.
par_en  in  1  1 = parity bit present.
par_typ  in  1  0 = even, 1 = odd.
rx_in  in  1  raw serial line, idle high, asynchronous.
busy  out  1  state != IDLE.
bit_strobe  out  1  one-cycle pulse per sampled bit.
bit_idx  out  4  index of strobed bit: 0-7 data, 8 parity, 9 stop.
bit_val  out  1  majority-voted value of strobed bit.
frame_done  out  1  one-cycle pulse at end of stop-bit sample.
rx_data  out  8  assembled byte, LSB first; updated with frame_done.
par_error  out  1  parity mismatch of last frame; 0 when parity disabled.
stop_error  out  1  stop bit sampled 0 in last frame.
false_start  out  1  one-cycle pulse when start bit fails qualification.

Behaviour:
- Reset (async, rst=0):
  - state IDLE, counters 0, both sync flops 1.
  - All outputs 0: busy, strobes, bit_idx, bit_val, rx_data, par_error, stop_error, false_start.
- Synchroniser: rx_in passes through 2 flops to give rx_s. A previous-value flop gives rx_p. Fall = rx_p & ~rx_s.
- Config latch: on IDLE->START, latch cpb = max(clks_per_bit, 4), par_en and par_typ. Mid-frame changes are ignored. half = cpb>>1.
- Bit timer:
  - cnt runs 0..cpb-1 within each bit; 0 in the first cycle of START.
  - rx_s is sampled at cnt = half-1, half and half+1; the majority gives the bit value.
  - All outputs are registered. bit_strobe, bit_idx and bit_val are asserted in the cycle after cnt == half+1.
- States:
  - IDLE: if rx_en & fall -> START.
  - START:
    - At the majority point, value 1 -> pulse false_start, go to IDLE; no bit strobe is issued.
    - Value 0 -> continue. At cnt == cpb-1 -> DATA, n=0.
  - DATA:
    - Strobe bit_idx=n; shift bit_val into bit n of the internal shift register.
    - At cnt == cpb-1: if n==7 -> PARITY if par_en, else STOP. Otherwise n++.
  - PARITY:
    - Strobe bit_idx=8.
    - perr = (^data ^ bit_val) != par_typ, i.e. even parity requires the total count of ones, including the parity bit, to be even.
    - At cnt == cpb-1 -> STOP.
  - STOP:
    - Strobe bit_idx=9.
    - In the same cycle as the strobe: frame_done=1, rx_data updated from the shift register, stop_error = ~bit_val, par_error = perr (0 if no parity).
    - Go to IDLE immediately, without waiting for the end of the stop bit.
- Error flags and rx_data hold until the next frame_done or reset.
- false_start does not modify rx_data or the error flags.
- rx_en low in any state: IDLE on the next clock, busy=0, no frame_done, held outputs unchanged. A frame in progress is abandoned.
- A fall detected in the cycle IDLE is entered is acted on: back-to-back frames are supported.
- Line held low while idle: no fall occurs, so it stays in IDLE. A break therefore cannot retrigger.
- Counter width is CPB_W. cpb=4 gives samples at 1, 2, 3.

Test Plan:
- cpb=16, no parity, send 0xA5 with stop=1 -> nine bit_strobes, idx 0..7 with values 1,0,1,0,0,1,0,1, then idx 9; frame_done once; rx_data=0xA5; par_error=0; stop_error=0.
- cpb=8, even parity, data 0x03:
  - Parity bit 0 -> par_error=0.
  - Repeat with parity bit 1 -> par_error=1.
  - Odd parity, 0x03, parity bit 1 -> par_error=0.
- rx_in low for 3 cycles then high, cpb=16 -> false_start pulses once; busy drops; no bit_strobe; rx_data unchanged.
- Stop bit driven 0, data 0x5A -> frame_done with rx_data=0x5A and stop_error=1. The next good frame clears stop_error to 0.
- rx_en deasserted during data bit 4 -> busy=0 the next cycle; no frame_done; a following full frame of 0x3C receives correctly.
- clks_per_bit=2 -> behaves as 4: each bit spans 4 cycles and 0x81 is received correctly. Assert rst mid-frame -> all outputs 0 immediately.
